// File: rtl/cache_line_responder_pkg.sv
// Shared types for the cache-line responder: line-interface structs, word-bus
// structs and the responder state encoding.
package cache_line_responder_pkg;

   localparam int unsigned LINE_W     = 128;
   localparam int unsigned WORD_W     = 32;
   localparam int unsigned ADDR_W     = 32;
   localparam int unsigned LINE_BEATS = LINE_W / WORD_W;

   typedef enum logic [1:0] {
      LRESP_IDLE,
      LRESP_BEAT,
      LRESP_RESP,
      LRESP_TURN
   } type_line_resp_states_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [LINE_W-1:0] w_data;
      logic              w_en;
      logic              req;
   } type_cache2mem_s;

   typedef struct packed {
      logic [LINE_W-1:0] r_data;
      logic              ack;
   } type_mem2cache_s;

   typedef struct packed {
      logic              req;
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [WORD_W-1:0] wdata;
   } type_resp2word_s;

   typedef struct packed {
      logic [WORD_W-1:0] rdata;
      logic              ack;
   } type_word2resp_s;

endpackage

// File: rtl/cache_line_responder.sv
// Serializes one cache-line request into word beats on a single-outstanding
// word bus and returns the assembled line (or a write completion) as a one-cycle ack.
module cache_line_responder
   import cache_line_responder_pkg::*;
#(
   parameter int LINE_WIDTH = LINE_W,
   parameter int WORD_WIDTH = WORD_W,
   parameter int ADDR_WIDTH = ADDR_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  type_cache2mem_s       cache2mem_i,
   output type_mem2cache_s       mem2cache_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [WORD_WIDTH-1:0] mem_wdata_o,
   input  logic [WORD_WIDTH-1:0] mem_rdata_i,
   input  logic                  mem_ack_i
);

   localparam int NBEATS = LINE_WIDTH / WORD_WIDTH;
   localparam int OFFS   = $clog2(LINE_WIDTH / 8);
   localparam int WOFFS  = $clog2(WORD_WIDTH / 8);
   localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

   function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [ADDR_WIDTH-1:0] line_addr,
                                                        input logic [CNT_W-1:0]      cnt);
      beat_addr = {line_addr[ADDR_WIDTH-1:OFFS], cnt, {WOFFS{1'b0}}};
   endfunction

   type_line_resp_states_e state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   kill_q, kill_d;
   logic                   kill_now;
   type_resp2word_s        word_q, word_d;
   type_word2resp_s        word_in;
   logic                   ack_q, ack_d;
   logic [LINE_WIDTH-1:0]  rdata_q, rdata_d;

   logic [ADDR_WIDTH-1:0]  line_addr_q, line_addr_d;
   logic [LINE_WIDTH-1:0]  wline_q, wline_d;
   logic                   we_q, we_d;
   logic [LINE_WIDTH-1:0]  buf_q, buf_d;

   assign word_in = '{rdata: mem_rdata_i, ack: mem_ack_i};

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      kill_d      = kill_q;
      word_d      = word_q;
      ack_d       = 1'b0;
      rdata_d     = rdata_q;
      line_addr_d = line_addr_q;
      wline_d     = wline_q;
      we_d        = we_q;
      buf_d       = buf_q;
      // a kill may be raised in the very cycle its beat completes
      kill_now    = kill_q | ~cache2mem_i.req;
      case (state_q)
         LRESP_IDLE: begin
            if (cache2mem_i.req) begin
               line_addr_d  = cache2mem_i.addr;
               wline_d      = cache2mem_i.w_data;
               we_d         = cache2mem_i.w_en;
               cnt_d        = '0;
               kill_d       = 1'b0;
               word_d.req   = 1'b1;
               word_d.we    = cache2mem_i.w_en;
               word_d.addr  = beat_addr(cache2mem_i.addr, '0);
               word_d.wdata = cache2mem_i.w_data[WORD_WIDTH-1:0];
               state_d      = LRESP_BEAT;
            end
         end
         LRESP_BEAT: begin
            if (word_in.ack) begin
               if (!we_q) buf_d[cnt_q*WORD_WIDTH +: WORD_WIDTH] = word_in.rdata;
               if (kill_now) begin
                  kill_d     = 1'b0;
                  word_d.req = 1'b0;
                  word_d.we  = 1'b0;
                  state_d    = LRESP_IDLE;
               end else if (cnt_q == LAST_BEAT) begin
                  word_d.req = 1'b0;
                  word_d.we  = 1'b0;
                  ack_d      = 1'b1;
                  rdata_d    = we_q ? '0 : buf_d;
                  state_d    = LRESP_RESP;
               end else begin
                  cnt_d        = cnt_q + 1'b1;
                  word_d.addr  = beat_addr(line_addr_q, cnt_d);
                  word_d.wdata = wline_q[cnt_d*WORD_WIDTH +: WORD_WIDTH];
               end
            end else begin
               kill_d = kill_now;
            end
         end
         LRESP_RESP: state_d = LRESP_TURN;
         LRESP_TURN: state_d = LRESP_IDLE;
         default:    state_d = LRESP_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= LRESP_IDLE;
         cnt_q   <= '0;
         kill_q  <= 1'b0;
         word_q  <= '0;
         ack_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         kill_q  <= kill_d;
         word_q  <= word_d;
         ack_q   <= ack_d;
         rdata_q <= rdata_d;
      end
   end

   // latched request and read assembly buffer carry no reset
   always_ff @(posedge clk) begin
      line_addr_q <= line_addr_d;
      wline_q     <= wline_d;
      we_q        <= we_d;
      buf_q       <= buf_d;
   end

   assign mem_req_o          = word_q.req;
   assign mem_we_o           = word_q.we;
   assign mem_addr_o         = word_q.addr;
   assign mem_wdata_o        = word_q.wdata;
   assign mem2cache_o.ack    = ack_q;
   assign mem2cache_o.r_data = rdata_q;

endmodule
